// File: rtl/axi_master_arbiter_r_if.sv
// AXI read-channel bundle (AR + R) used on both the master-facing and
// slave-facing sides of the read arbiter.
interface axi_master_arbiter_r_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic [USER_WIDTH-1:0] RUSER;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RUSER, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RUSER, RVALID
  );
endinterface

// File: rtl/axi_master_arbiter_r.sv
// Two-master AXI read arbiter: round-robin grant, one burst in flight, grant
// held from AR issue through the RLAST handshake so R routes without ID decode.
module axi_master_arbiter_r #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1,
  parameter int TCO        = 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  axi_master_arbiter_r_if.slave   m0,
  axi_master_arbiter_r_if.slave   m1,
  axi_master_arbiter_r_if.master  s
);

  // TCO only models clock-to-out in simulation; synthesizable RTL carries no delays.
  if (TCO < 0) begin : g_tco_invalid
    $error("TCO must be non-negative");
  end

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e state, state_nxt;
  logic   grant, grant_nxt;
  logic   last_grant, last_grant_nxt;

  logic                  sel_arvalid;
  logic [ID_WIDTH-1:0]   sel_arid;
  logic [ADDR_WIDTH-1:0] sel_araddr;
  logic [7:0]            sel_arlen;
  logic [2:0]            sel_arsize;
  logic [1:0]            sel_arburst;
  logic                  sel_rready;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      // NOTE: non-blocking so all three registers update from pre-edge values.
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Granted master's AR fields and R-side ready, before window gating.
  always_comb begin
    if (grant) begin
      sel_arvalid = m1.ARVALID;
      sel_arid    = m1.ARID;
      sel_araddr  = m1.ARADDR;
      sel_arlen   = m1.ARLEN;
      sel_arsize  = m1.ARSIZE;
      sel_arburst = m1.ARBURST;
      sel_rready  = m1.RREADY;
    end else begin
      sel_arvalid = m0.ARVALID;
      sel_arid    = m0.ARID;
      sel_araddr  = m0.ARADDR;
      sel_arlen   = m0.ARLEN;
      sel_arsize  = m0.ARSIZE;
      sel_arburst = m0.ARBURST;
      sel_rready  = m0.RREADY;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (m0.ARVALID || m1.ARVALID) begin
          // A tie goes to whoever did not win last time.
          grant_nxt      = (m0.ARVALID && m1.ARVALID) ? ~last_grant : m1.ARVALID;
          last_grant_nxt = grant_nxt;
          state_nxt      = ADDR;
        end
      end
      ADDR: if (sel_arvalid && s.ARREADY) state_nxt = DATA;
      DATA: if (s.RVALID && sel_rready && s.RLAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s.ARVALID  = 1'b0;
    s.ARID     = '0;
    s.ARADDR   = '0;
    s.ARLEN    = '0;
    s.ARSIZE   = '0;
    s.ARBURST  = '0;
    s.RREADY   = 1'b0;

    m0.ARREADY = 1'b0;
    m0.RVALID  = 1'b0;
    m0.RID     = '0;
    m0.RDATA   = {DATA_WIDTH{1'b0}};
    m0.RRESP   = '0;
    m0.RLAST   = 1'b0;
    m0.RUSER   = {USER_WIDTH{1'b0}};

    m1.ARREADY = 1'b0;
    m1.RVALID  = 1'b0;
    m1.RID     = '0;
    m1.RDATA   = {DATA_WIDTH{1'b0}};
    m1.RRESP   = '0;
    m1.RLAST   = 1'b0;
    m1.RUSER   = {USER_WIDTH{1'b0}};

    unique case (state)
      ADDR: begin
        s.ARVALID = sel_arvalid;
        s.ARID    = sel_arid;
        s.ARADDR  = sel_araddr;
        s.ARLEN   = sel_arlen;
        s.ARSIZE  = sel_arsize;
        s.ARBURST = sel_arburst;
        if (grant) m1.ARREADY = s.ARREADY;
        else       m0.ARREADY = s.ARREADY;
      end
      DATA: begin
        s.RREADY = sel_rready;
        if (grant) begin
          m1.RVALID = s.RVALID;
          m1.RID    = s.RID;
          m1.RDATA  = s.RDATA;
          m1.RRESP  = s.RRESP;
          m1.RLAST  = s.RLAST;
          m1.RUSER  = s.RUSER;
        end else begin
          m0.RVALID = s.RVALID;
          m0.RID    = s.RID;
          m0.RDATA  = s.RDATA;
          m0.RRESP  = s.RRESP;
          m0.RLAST  = s.RLAST;
          m0.RUSER  = s.RUSER;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_master_arbiter_r.sv
// Directed bench for axi_master_arbiter_r; a per-master beat scoreboard checks
// that every forwarded R beat reaches the right requester exactly once.
module tb_axi_master_arbiter_r;

  logic ACLK;
  logic ARESETn;

  axi_master_arbiter_r_if m0_if ();
  axi_master_arbiter_r_if m1_if ();
  axi_master_arbiter_r_if s_if ();

  axi_master_arbiter_r dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [3:0]   id;
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
    logic [0:0]   user;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop and compare whenever a master takes a beat.
  always @(negedge ACLK) begin
    beat_t e;
    if (m0_if.RVALID && m0_if.RREADY) begin
      if (q0.size() == 0) check("m0_unexpected_beat", 160'(m0_if.RVALID), 160'(1'b0));
      else begin
        e = q0.pop_front();
        check("m0_beat", 160'({m0_if.RID, m0_if.RDATA, m0_if.RRESP, m0_if.RLAST, m0_if.RUSER}), 160'(e));
      end
    end
    if (m1_if.RVALID && m1_if.RREADY) begin
      if (q1.size() == 0) check("m1_unexpected_beat", 160'(m1_if.RVALID), 160'(1'b0));
      else begin
        e = q1.pop_front();
        check("m1_beat", 160'({m1_if.RID, m1_if.RDATA, m1_if.RRESP, m1_if.RLAST, m1_if.RUSER}), 160'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_arvalid"}, 160'(s_if.ARVALID), 160'(1'b0));
    check({tag, "_s_araddr"},  160'(s_if.ARADDR),  160'(32'h0));
    check({tag, "_s_rready"},  160'(s_if.RREADY),  160'(1'b0));
    check({tag, "_m0_arready"}, 160'(m0_if.ARREADY), 160'(1'b0));
    check({tag, "_m1_arready"}, 160'(m1_if.ARREADY), 160'(1'b0));
    check({tag, "_m0_rvalid"}, 160'(m0_if.RVALID), 160'(1'b0));
    check({tag, "_m1_rvalid"}, 160'(m1_if.RVALID), 160'(1'b0));
    check({tag, "_m0_rdata"},  160'(m0_if.RDATA),  160'(128'h0));
    check({tag, "_m1_rdata"},  160'(m1_if.RDATA),  160'(128'h0));
  endtask

  task automatic raise_ar(input bit mst, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len);
    if (mst) begin
      m1_if.ARID = id; m1_if.ARADDR = addr; m1_if.ARLEN = len;
      m1_if.ARSIZE = 3'd4; m1_if.ARBURST = 2'b01; m1_if.ARVALID = 1'b1;
    end else begin
      m0_if.ARID = id; m0_if.ARADDR = addr; m0_if.ARLEN = len;
      m0_if.ARSIZE = 3'd4; m0_if.ARBURST = 2'b01; m0_if.ARVALID = 1'b1;
    end
  endtask

  // Waits at most max_wait negedges for the AR handshake of master mst.
  task automatic wait_ar(input bit mst, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input int max_wait, input string tag);
    int guard = 0;
    forever begin
      @(negedge ACLK);
      if (s_if.ARVALID && s_if.ARREADY) break;
      guard++;
      if (guard >= max_wait) begin
        check({tag, "_ar_timeout"}, 160'(s_if.ARVALID && s_if.ARREADY), 160'(1'b1));
        return;
      end
    end
    check({tag, "_araddr"},  160'(s_if.ARADDR),  160'(addr));
    check({tag, "_arid"},    160'(s_if.ARID),    160'(id));
    check({tag, "_arlen"},   160'(s_if.ARLEN),   160'(len));
    check({tag, "_arburst"}, 160'(s_if.ARBURST), 160'(2'b01));
    check({tag, "_own_arready"},   160'(mst ? m1_if.ARREADY : m0_if.ARREADY), 160'(1'b1));
    check({tag, "_other_arready"}, 160'(mst ? m0_if.ARREADY : m1_if.ARREADY), 160'(1'b0));
    tick();
    if (mst) m1_if.ARVALID = 1'b0;
    else     m0_if.ARVALID = 1'b0;
  endtask

  task automatic send_beats(input bit mst, input int n, input logic [3:0] id,
                            input logic [127:0] base, input bit ends_burst, input bit toggle);
    beat_t b;
    logic  rr;
    bit    hs;
    for (int i = 0; i < n; i++) begin
      b.id   = id;
      b.data = base + 128'(i);
      b.resp = 2'(i);
      b.last = ends_burst && (i == n - 1);
      b.user = 1'(i);
      s_if.RID = b.id; s_if.RDATA = b.data; s_if.RRESP = b.resp;
      s_if.RLAST = b.last; s_if.RUSER = b.user; s_if.RVALID = 1'b1;
      if (mst) q1.push_back(b);
      else     q0.push_back(b);
      for (int guard = 0; ; guard++) begin
        rr = toggle ? 1'(guard) : 1'b1;
        if (mst) m1_if.RREADY = rr;
        else     m0_if.RREADY = rr;
        @(negedge ACLK);
        check("other_rvalid", 160'(mst ? m0_if.RVALID : m1_if.RVALID), 160'(1'b0));
        if (toggle) check("rready_mirror", 160'(s_if.RREADY), 160'(rr));
        hs = s_if.RVALID && s_if.RREADY;
        tick();
        if (hs) break;
        if (guard > 20) begin
          check("beat_timeout", 160'(hs), 160'(1'b1));
          break;
        end
      end
    end
    s_if.RVALID = 1'b0;
    s_if.RLAST  = 1'b0;
    m0_if.RREADY = 1'b1;
    m1_if.RREADY = 1'b1;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
  endtask

  initial begin
    ARESETn = 1'b0;
    m0_if.ARVALID = 1'b0; m0_if.ARID = '0; m0_if.ARADDR = '0; m0_if.ARLEN = '0;
    m0_if.ARSIZE = '0; m0_if.ARBURST = '0; m0_if.RREADY = 1'b1;
    m1_if.ARVALID = 1'b0; m1_if.ARID = '0; m1_if.ARADDR = '0; m1_if.ARLEN = '0;
    m1_if.ARSIZE = '0; m1_if.ARBURST = '0; m1_if.RREADY = 1'b1;
    s_if.ARREADY = 1'b1; s_if.RVALID = 1'b0; s_if.RID = '0; s_if.RDATA = '0;
    s_if.RRESP = '0; s_if.RLAST = 1'b0; s_if.RUSER = '0;

    // Reset: outputs quiet even with a request pending.
    #2;
    check_all_zero("reset");
    tick();
    raise_ar(1'b0, 4'h1, 32'h1C00_0000, 8'd3);
    @(negedge ACLK);
    check_all_zero("reset_req");
    m0_if.ARVALID = 1'b0;
    ARESETn = 1'b1;
    tick();

    // Single m0 read: one-cycle arbitration latency, four beats to m0 only.
    raise_ar(1'b0, 4'h1, 32'h1C00_0000, 8'd3);
    @(negedge ACLK);
    check("t1_arvalid_idle", 160'(s_if.ARVALID), 160'(1'b0));
    wait_ar(1'b0, 4'h1, 32'h1C00_0000, 8'd3, 1, "t1");
    send_beats(1'b0, 4, 4'h1, 128'h1, 1'b1, 1'b0);
    @(negedge ACLK);
    check("t1_idle_rready", 160'(s_if.RREADY), 160'(1'b0));
    check("t1_idle_arvalid", 160'(s_if.ARVALID), 160'(1'b0));
    tick();

    // Tie from reset: m0 first, m1 exactly two cycles after m0's RLAST.
    do_reset();
    raise_ar(1'b0, 4'h2, 32'h0000_1000, 8'd1);
    raise_ar(1'b1, 4'h3, 32'h0000_2000, 8'd1);
    wait_ar(1'b0, 4'h2, 32'h0000_1000, 8'd1, 2, "t2_m0");
    send_beats(1'b0, 2, 4'h2, 128'h100, 1'b1, 1'b0);
    @(negedge ACLK);
    check("t2_turnaround_arvalid", 160'(s_if.ARVALID), 160'(1'b0));
    check("t2_m1_pending", 160'(m1_if.ARVALID), 160'(1'b1));
    wait_ar(1'b1, 4'h3, 32'h0000_2000, 8'd1, 1, "t2_m1");
    send_beats(1'b1, 2, 4'h3, 128'h200, 1'b1, 1'b0);

    // Next tie after m1 won: m0 again, then the pending m1.
    raise_ar(1'b0, 4'h4, 32'h0000_3000, 8'd0);
    raise_ar(1'b1, 4'h5, 32'h0000_4000, 8'd0);
    wait_ar(1'b0, 4'h4, 32'h0000_3000, 8'd0, 2, "t2b_m0");
    send_beats(1'b0, 1, 4'h4, 128'h300, 1'b1, 1'b0);
    wait_ar(1'b1, 4'h5, 32'h0000_4000, 8'd0, 2, "t2b_m1");
    send_beats(1'b1, 1, 4'h5, 128'h400, 1'b1, 1'b0);

    // AR backpressure with a spurious beat offered, then toggling RREADY.
    s_if.ARREADY = 1'b0;
    raise_ar(1'b0, 4'h6, 32'h5000_0040, 8'd2);
    @(negedge ACLK);
    s_if.RVALID = 1'b1; s_if.RLAST = 1'b1; s_if.RDATA = 128'hBAD;
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge ACLK);
      check("t3_arvalid_held", 160'(s_if.ARVALID), 160'(1'b1));
      check("t3_araddr_stable", 160'(s_if.ARADDR), 160'(32'h5000_0040));
      check("t3_m0_arready_low", 160'(m0_if.ARREADY), 160'(1'b0));
      check("t3_addr_rready_low", 160'(s_if.RREADY), 160'(1'b0));
      check("t3_addr_m0_rvalid", 160'(m0_if.RVALID), 160'(1'b0));
    end
    tick();
    s_if.RVALID = 1'b0; s_if.RLAST = 1'b0;
    s_if.ARREADY = 1'b1;
    wait_ar(1'b0, 4'h6, 32'h5000_0040, 8'd2, 1, "t3");
    send_beats(1'b0, 3, 4'h6, 128'h500, 1'b1, 1'b1);

    // Spurious beat while IDLE must be neither accepted nor forwarded.
    s_if.RVALID = 1'b1; s_if.RLAST = 1'b1; s_if.RDATA = 128'hDEAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge ACLK);
      check("t4_rready", 160'(s_if.RREADY), 160'(1'b0));
      check("t4_m0_rvalid", 160'(m0_if.RVALID), 160'(1'b0));
      check("t4_m1_rvalid", 160'(m1_if.RVALID), 160'(1'b0));
      check("t4_m0_rdata", 160'(m0_if.RDATA), 160'(128'h0));
      tick();
    end
    s_if.RVALID = 1'b0; s_if.RLAST = 1'b0;

    // Reset during beat 2 of a 4-beat burst, then a fresh m1 read.
    raise_ar(1'b0, 4'h7, 32'h0000_6000, 8'd3);
    wait_ar(1'b0, 4'h7, 32'h0000_6000, 8'd3, 2, "t5");
    send_beats(1'b0, 1, 4'h7, 128'h600, 1'b0, 1'b0);
    m0_if.RREADY = 1'b0;
    s_if.RVALID = 1'b1; s_if.RDATA = 128'h601; s_if.RID = 4'h7;
    @(negedge ACLK);
    check("t5_beat2_visible", 160'(m0_if.RVALID), 160'(1'b1));
    check("t5_beat2_data", 160'(m0_if.RDATA), 160'(128'h601));
    #1;
    ARESETn = 1'b0;
    #1;
    check_all_zero("t5_reset");
    @(posedge ACLK);
    @(negedge ACLK);
    s_if.RVALID = 1'b0;
    m0_if.RREADY = 1'b1;
    ARESETn = 1'b1;
    tick();
    raise_ar(1'b1, 4'h8, 32'h0000_7000, 8'd1);
    wait_ar(1'b1, 4'h8, 32'h0000_7000, 8'd1, 2, "t5_m1");
    send_beats(1'b1, 2, 4'h8, 128'h700, 1'b1, 1'b0);
    @(negedge ACLK);

    check("q0_drained", 160'(q0.size()), 160'(0));
    check("q1_drained", 160'(q1.size()), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
